// File: rtl/jt1942_romrq_pkg.sv
// Shared types and constants for the main-CPU ROM request block.
package jt1942_romrq_pkg;

  localparam int ROMRQ_AW = 17;
  localparam int SDW      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } romrq_state_e;

endpackage

// File: rtl/jt1942_romrq_entry.sv
// One buffered SDRAM word: valid/tag/word storage plus the tag compare.
module jt1942_romrq_entry #(
  parameter int AW  = jt1942_romrq_pkg::ROMRQ_AW,
  parameter int SDW = jt1942_romrq_pkg::SDW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-2:0] wtag,
  input  logic [SDW-1:0] wdata,
  input  logic [AW-2:0] ltag,
  output logic          hit,
  output logic [SDW-1:0] word
);

  logic          valid;
  logic [AW-2:0] tag;

  // clr wins over we so a download can never leave a stale entry valid
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      word  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (we) begin
      valid <= 1'b1;
      tag   <= wtag;
      word  <= wdata;
    end
  end

  assign hit = valid && (tag == ltag);

endmodule

// File: rtl/jt1942_main_romrq.sv
// Main-CPU ROM request: word buffer in front of the SDRAM controller.
// Define JT1942_ROMRQ_CACHE2_EN for a two-entry buffer with 1-bit LRU.
module jt1942_main_romrq #(
  parameter int AW  = jt1942_romrq_pkg::ROMRQ_AW,
  parameter int SDW = jt1942_romrq_pkg::SDW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [AW-1:0] addr,
  input  logic          addr_ok,
  input  logic          downloading,
  output logic [7:0]    dout,
  output logic          data_ok,
  output logic [AW-2:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [SDW-1:0] sdram_din
);

  import jt1942_romrq_pkg::*;

`ifdef JT1942_ROMRQ_CACHE2_EN
  localparam int NE = 2;
`else
  localparam int NE = 1;
`endif

  romrq_state_e          state, state_nx;
  logic                  req_nx;
  logic [AW-2:0]         addr_nx;
  logic                  fill_en;
  logic                  hit_any;
  logic [NE-1:0]         hit;
  logic [NE-1:0]         we;
  logic [NE-1:0][SDW-1:0] word;
  logic [SDW-1:0]        sel_word;

  genvar g;
  generate
    for (g = 0; g < NE; g++) begin : g_entry
      jt1942_romrq_entry #(.AW(AW), .SDW(SDW)) u_entry (
        .clk   (clk),
        .rst   (rst),
        .clr   (downloading),
        .we    (we[g]),
        .wtag  (sdram_addr),
        .wdata (sdram_din),
        .ltag  (addr[AW-1:1]),
        .hit   (hit[g]),
        .word  (word[g])
      );
    end
  endgenerate

  assign hit_any = |hit;
  assign data_ok = addr_ok && hit_any;

  always_comb begin
    sel_word = word[0];
    for (int i = 0; i < NE; i++)
      if (hit[i]) sel_word = word[i];
  end

  assign dout = addr[0] ? sel_word[15:8] : sel_word[7:0];

  // ack and data_rdy in the same cycle take the fill path straight from REQ
  assign fill_en = !downloading && data_rdy &&
                   ((state == WAIT) || (state == REQ && sdram_ack));

`ifdef JT1942_ROMRQ_CACHE2_EN
  // lru names the entry to replace next
  logic lru;

  always_ff @(posedge clk) begin
    if (rst)          lru <= 1'b0;
    else if (fill_en) lru <= ~lru;
    else if (data_ok) lru <= hit[0];
  end

  assign we = {fill_en & lru, fill_en & ~lru};
`else
  assign we = fill_en;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      state      <= state_nx;
      sdram_req  <= req_nx;
      sdram_addr <= addr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    req_nx   = sdram_req;
    addr_nx  = sdram_addr;
    case (state)
      IDLE: if (cen && addr_ok && !hit_any && !downloading) begin
        addr_nx  = addr[AW-1:1];
        req_nx   = 1'b1;
        state_nx = REQ;
      end
      REQ: if (sdram_ack) begin
        req_nx   = 1'b0;
        state_nx = data_rdy ? IDLE : WAIT;
      end
      WAIT: if (data_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jt1942_main_romrq.sv
// Directed bench for jt1942_main_romrq; follows JT1942_ROMRQ_CACHE2_EN if defined.
module tb_jt1942_main_romrq;

  logic        clk = 1'b0;
  logic        rst, cen, addr_ok, downloading, sdram_ack, data_rdy;
  logic [16:0] addr;
  logic [15:0] sdram_din;
  logic [7:0]  dout;
  logic        data_ok, sdram_req;
  logic [15:0] sdram_addr;

  int n_chk  = 0;
  int n_fail = 0;

  jt1942_main_romrq dut (
    .clk         (clk),
    .rst         (rst),
    .cen         (cen),
    .addr        (addr),
    .addr_ok     (addr_ok),
    .downloading (downloading),
    .dout        (dout),
    .data_ok     (data_ok),
    .sdram_addr  (sdram_addr),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .sdram_din   (sdram_din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !sdram_req; i++) tick();
    chk("req_seen", sdram_req, 1);
  endtask

  task automatic fill(input logic [16:0] a, input logic [15:0] d);
    addr = a; addr_ok = 1'b1;
    tick();
    wait_req();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0; data_rdy = 1'b1; sdram_din = d;
    tick();
    data_rdy = 1'b0;
    #1;
  endtask

  initial begin
    cen = 1'b1; addr = '0; addr_ok = 1'b0; downloading = 1'b0;
    sdram_ack = 1'b0; data_rdy = 1'b0; sdram_din = '0;
    do_reset();
    chk("rst_req", sdram_req, 0);
    chk("rst_saddr", sdram_addr, 0);
    chk("rst_ok", data_ok, 0);
    chk("rst_dout", dout, 0);

    // 1: first miss and fill
    addr = 17'h00010; addr_ok = 1'b1; #1;
    chk("s1_miss", data_ok, 0);
    tick();
    chk("s1_req", sdram_req, 1);
    chk("s1_saddr", sdram_addr, 16'h0008);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk("s1_req_drop", sdram_req, 0);
    data_rdy = 1'b1; sdram_din = 16'hBEEF;
    tick();
    data_rdy = 1'b0; #1;
    chk("s1_ok", data_ok, 1);
    chk("s1_dout", dout, 8'hEF);
    tick();
    chk("s1_noreq", sdram_req, 0);

    // 2: other byte of same word hits immediately
    addr = 17'h00011; #1;
    chk("s2_ok", data_ok, 1);
    chk("s2_dout", dout, 8'hBE);
    tick();
    chk("s2_noreq", sdram_req, 0);

    // 3: address change while request outstanding
    addr = 17'h08000; #1;
    chk("s3_miss", data_ok, 0);
    tick();
    chk("s3_req", sdram_req, 1);
    chk("s3_saddr", sdram_addr, 16'h4000);
    addr = 17'h0C000; sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk("s3_saddr_hold", sdram_addr, 16'h4000);
    data_rdy = 1'b1; sdram_din = 16'h5555;
    tick();
    data_rdy = 1'b0; #1;
    chk("s3_new_miss", data_ok, 0);
    addr = 17'h08000; #1;
    chk("s3_old_fill", data_ok, 1);
    chk("s3_old_dout", dout, 8'h55);
    addr = 17'h0C000; #1;
    tick();
    chk("s3_req2", sdram_req, 1);
    chk("s3_saddr2", sdram_addr, 16'h6000);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0; data_rdy = 1'b1; sdram_din = 16'hA1B2;
    tick();
    data_rdy = 1'b0; #1;
    chk("s3_ok", data_ok, 1);
    chk("s3_dout", dout, 8'hB2);

    // 4: downloading during WAIT drops the fill
    addr = 17'h00100; #1;
    tick();
    chk("s4_req", sdram_req, 1);
    chk("s4_saddr", sdram_addr, 16'h0080);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0; downloading = 1'b1;
    tick();
    data_rdy = 1'b1; sdram_din = 16'h7777;
    tick();
    data_rdy = 1'b0; #1;
    chk("s4_nofill", data_ok, 0);
    tick();
    chk("s4_dl_noreq", sdram_req, 0);
    downloading = 1'b0; addr = 17'h0C000; #1;
    chk("s4_old_miss", data_ok, 0);
    tick();
    chk("s4_idle_req", sdram_req, 1);
    chk("s4_idle_saddr", sdram_addr, 16'h6000);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0; data_rdy = 1'b1; sdram_din = 16'h0C0C;
    tick();
    data_rdy = 1'b0; #1;
    chk("s4_refill", dout, 8'h0C);

    // addr_ok low and cen low both hold off a request
    addr = 17'h00200; addr_ok = 1'b0; #1;
    chk("aok_lo_ok", data_ok, 0);
    tick(); tick();
    chk("aok_lo_noreq", sdram_req, 0);
    addr_ok = 1'b1; cen = 1'b0;
    tick();
    chk("cen_lo_noreq", sdram_req, 0);
    cen = 1'b1;
    tick();
    chk("cen_hi_saddr", sdram_addr, 16'h0100);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0; data_rdy = 1'b1; sdram_din = 16'h3344;
    tick();
    data_rdy = 1'b0; #1;
    chk("cen_dout", dout, 8'h44);

    // 5: ack and data_rdy together
    addr = 17'h00001; #1;
    tick();
    chk("s5_saddr", sdram_addr, 16'h0000);
    sdram_ack = 1'b1; data_rdy = 1'b1; sdram_din = 16'h1234;
    tick();
    sdram_ack = 1'b0; data_rdy = 1'b0; #1;
    chk("s5_ok", data_ok, 1);
    chk("s5_dout", dout, 8'h12);
    tick();
    chk("s5_noreq", sdram_req, 0);

    // reset mid-request; a late data_rdy is ignored
    addr = 17'h00400; #1;
    tick();
    chk("mrst_req", sdram_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; addr_ok = 1'b0;
    chk("mrst_req0", sdram_req, 0);
    chk("mrst_saddr0", sdram_addr, 0);
    data_rdy = 1'b1; sdram_din = 16'hFFFF;
    tick();
    data_rdy = 1'b0; addr_ok = 1'b1; #1;
    chk("mrst_nofill", data_ok, 0);

    // 6: two hot addresses
    do_reset();
    fill(17'h00000, 16'h1111);
    fill(17'h10000, 16'h2222);
`ifdef JT1942_ROMRQ_CACHE2_EN
    for (int i = 0; i < 4; i++) begin
      addr = (i % 2 == 0) ? 17'h00000 : 17'h10000; #1;
      chk("s6_alt_ok", data_ok, 1);
      chk("s6_alt_dout", dout, (i % 2 == 0) ? 8'h11 : 8'h22);
      tick();
      chk("s6_alt_noreq", sdram_req, 0);
    end
    fill(17'h00100, 16'h3333);
    addr = 17'h10000; #1;
    chk("s6_keep_mru", data_ok, 1);
    chk("s6_keep_dout", dout, 8'h22);
    addr = 17'h00000; #1;
    chk("s6_evict_lru", data_ok, 0);
`else
    addr = 17'h00000; #1;
    chk("s6_single_evict", data_ok, 0);
    addr = 17'h10000; #1;
    chk("s6_single_hit", data_ok, 1);
    chk("s6_single_dout", dout, 8'h22);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
